multicycle_ctrl_fsm: RTL and testbench
======================================

// Module: multicycle_ctrl_fsm
// PURPOSE
//  Parametrised multicycle CPU control unit; successor to the fixed-latency controller.
//  Sits between the instruction register opcode field and the datapath muxes/enables.
//  Adds a memory handshake (mem_ready), variable memory latency, a bounded wait timeout,
//  a jump path, and an illegal-opcode/timeout trap that redirects the PC to the trap vector.
// PARAMETERS
//  OPCODE_W     6           opcode field width
//  OP_RTYPE     6'b000000   R-type opcode
//  OP_ADDI      6'b001000   add-immediate opcode
//  OP_LW        6'b100011   load-word opcode
//  OP_SW        6'b101011   store-word opcode
//  OP_BEQ       6'b000100   branch-if-equal opcode
//  OP_J         6'b000010   jump opcode
//  MEM_TIMEOUT  15          max stalled cycles in a memory state before trap (1..255)
// PORTS
//  clk          in   1         clock, rising edge
//  reset        in   1         asynchronous, active-low reset
//  Opcode       in   OPCODE_W  IR opcode; sampled in DECODE only
//  mem_ready    in   1         memory completes the current MemRead/MemWrite this cycle
//  ALUOp        out  3         000 add, 001 sub, 010 funct-decode, 011 add-imm
//  ALUSrcA      out  1         0 = PC, 1 = reg A
//  ALUSrcB      out  2         00 reg B, 01 const 4, 10 sign-ext imm, 11 imm<<2
//  PCWrite      out  1         unconditional PC load
//  PCSource     out  2         00 ALU, 01 ALUOut, 10 jump target, 11 trap vector
//  PCWriteCond  out  1         PC load if ALU zero
//  MemRead, MemWrite out 1 each  memory request, held until mem_ready
//  MemToReg, RegDst, RegWrite, IRWrite  out 1 each  datapath writeback/IR controls
//  trap         out  1         one-cycle pulse while in TRAP
//  state        out  4         current state (debug)
//  next_state   out  4         combinational next state (debug)
// BEHAVIOUR
//  States: FETCH=0 DECODE=1 MEM_ADDR=2 MEM_RD=3 MEM_WB=4 MEM_WR=5 EXEC=6 R_WB=7
//   BRANCH=8 JUMP=9 IMM_EXEC=10 IMM_WB=11 TRAP=12; codes 13-15 -> FETCH next cycle.
//  reset low: state=next_state=FETCH, wait counter=0, every control output and trap = 0
//   (overrides the FETCH decode). Reset mid-instruction aborts it; nothing is written.
//  Outputs are decoded from state; deasserted unless listed:
//  FETCH: MemRead=1, ALUSrcA=0, ALUSrcB=01, ALUOp=000. IRWrite=PCWrite=mem_ready
//   (gated, same cycle). Stays in FETCH until mem_ready=1, then goes to DECODE.
//  DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=000. Next: LW/SW->MEM_ADDR, RTYPE->EXEC,
//   ADDI->IMM_EXEC, BEQ->BRANCH, J->JUMP, any other opcode->TRAP.
//  MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=000; ->MEM_RD if LW, ->MEM_WR if SW.
//  MEM_RD: MemRead=1; ->MEM_WB on mem_ready.  MEM_WB: RegWrite=1, MemToReg=1, RegDst=0; ->FETCH.
//  MEM_WR: MemWrite=1; ->FETCH on mem_ready.
//  EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=010; ->R_WB.  R_WB: RegWrite=1, RegDst=1; ->FETCH.
//  IMM_EXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=011; ->IMM_WB.  IMM_WB: RegWrite=1, RegDst=0; ->FETCH.
//  BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=001, PCWriteCond=1, PCSource=01; ->FETCH.
//  JUMP: PCWrite=1, PCSource=10; ->FETCH.
//  TRAP: PCWrite=1, PCSource=11, trap=1; ->FETCH. Single cycle.
//  Wait counter (8b): clears on every state change; increments each cycle spent in
//   FETCH/MEM_RD/MEM_WR with mem_ready=0. When it equals MEM_TIMEOUT and mem_ready is
//   still 0, next_state=TRAP and MemRead/MemWrite drop on entry to TRAP.
//   If mem_ready=1 in the timeout cycle, the access completes normally (ready wins).
//  Minimum latency with zero-wait memory: R/ADDI 4 cyc, LW 5, SW 4, BEQ/J 3, illegal 3.
//  Opcode is ignored outside DECODE. mem_ready is ignored outside memory states.
// TESTING
//  T1 reset low mid-MEM_RD -> state=0, all outputs 0 asynchronously; resumes FETCH after release.
//  T2 Opcode=000000, mem_ready=1 -> states 0,1,6,7,0; R_WB has RegWrite=1, RegDst=1.
//  T3 Opcode=100011, mem_ready low 3 cyc in MEM_RD -> MEM_RD held 4 cyc, MemRead=1 throughout,
//   then MEM_WB with MemToReg=1.
//  T4 Opcode=111100 (illegal) -> 0,1,12,0; trap=1 for 1 cycle with PCSource=11, PCWrite=1.
//  T5 mem_ready stuck 0 in FETCH -> TRAP after 16 cycles (MEM_TIMEOUT=15), IRWrite never 1.
//  T6 Opcode=000100 then 000010 -> BRANCH asserts PCWriteCond, PCSource=01; JUMP asserts
//   PCWrite, PCSource=10; each returns to FETCH next cycle.

Source files
------------

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle CPU control unit: decodes the IR opcode into datapath controls, with a memory
// handshake, a bounded memory-wait timeout and an illegal-opcode/timeout trap.
module multicycle_ctrl_fsm #(
  parameter int unsigned          OPCODE_W    = 6,
  parameter logic [OPCODE_W-1:0]  OP_RTYPE    = 6'b000000,
  parameter logic [OPCODE_W-1:0]  OP_ADDI     = 6'b001000,
  parameter logic [OPCODE_W-1:0]  OP_LW       = 6'b100011,
  parameter logic [OPCODE_W-1:0]  OP_SW       = 6'b101011,
  parameter logic [OPCODE_W-1:0]  OP_BEQ      = 6'b000100,
  parameter logic [OPCODE_W-1:0]  OP_J        = 6'b000010,
  parameter int unsigned          MEM_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] Opcode,
  input  logic                mem_ready,
  output logic [2:0]          ALUOp,
  output logic                ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic                PCWrite,
  output logic [1:0]          PCSource,
  output logic                PCWriteCond,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                MemToReg,
  output logic                RegDst,
  output logic                RegWrite,
  output logic                IRWrite,
  output logic                trap,
  output logic [3:0]          state,
  output logic [3:0]          next_state
);

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAddr = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StExec    = 4'd6,
    StRWb     = 4'd7,
    StBranch  = 4'd8,
    StJump    = 4'd9,
    StImmExec = 4'd10,
    StImmWb   = 4'd11,
    StTrap    = 4'd12
  } state_e;

  localparam logic [7:0] TimeoutCnt = 8'(MEM_TIMEOUT);

  state_e     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic       is_load_q, is_load_d;
  logic       mem_wait;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StFetch;
      wait_q    <= 8'd0;
      is_load_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      is_load_q <= is_load_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    is_load_d = is_load_q;
    mem_wait  = 1'b0;
    case (state_q)
      StFetch: begin
        mem_wait = 1'b1;
        if (mem_ready) state_d = StDecode;
      end
      StDecode: begin
        // Opcode is only valid here, so remember load vs store for MEM_ADDR.
        is_load_d = (Opcode == OP_LW);
        if (Opcode == OP_LW || Opcode == OP_SW) state_d = StMemAddr;
        else if (Opcode == OP_RTYPE)            state_d = StExec;
        else if (Opcode == OP_ADDI)             state_d = StImmExec;
        else if (Opcode == OP_BEQ)              state_d = StBranch;
        else if (Opcode == OP_J)                state_d = StJump;
        else                                    state_d = StTrap;
      end
      StMemAddr: state_d = is_load_q ? StMemRd : StMemWr;
      StMemRd: begin
        mem_wait = 1'b1;
        if (mem_ready) state_d = StMemWb;
      end
      StMemWr: begin
        mem_wait = 1'b1;
        if (mem_ready) state_d = StFetch;
      end
      StExec:    state_d = StRWb;
      StImmExec: state_d = StImmWb;
      StMemWb, StRWb, StImmWb, StBranch, StJump, StTrap: state_d = StFetch;
      default:   state_d = StFetch;
    endcase

    // A ready in the timeout cycle still completes the access.
    if (mem_wait && !mem_ready && wait_q >= TimeoutCnt) state_d = StTrap;

    if (!reset) state_d = StFetch;
  end

  always_comb begin
    if (state_d != state_q)        wait_d = 8'd0;
    else if (mem_wait && !mem_ready) wait_d = wait_q + 8'd1;
    else                           wait_d = wait_q;
  end

  always_comb begin
    ALUOp       = 3'b000;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    PCWrite     = 1'b0;
    PCSource    = 2'b00;
    PCWriteCond = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemToReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    IRWrite     = 1'b0;
    trap        = 1'b0;
    if (reset) begin
      case (state_q)
        StFetch: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        StDecode: ALUSrcB = 2'b11;
        StMemAddr: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        StMemRd: MemRead = 1'b1;
        StMemWb: begin
          RegWrite = 1'b1;
          MemToReg = 1'b1;
        end
        StMemWr: MemWrite = 1'b1;
        StExec: begin
          ALUSrcA = 1'b1;
          ALUOp   = 3'b010;
        end
        StRWb: begin
          RegWrite = 1'b1;
          RegDst   = 1'b1;
        end
        StImmExec: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          ALUOp   = 3'b011;
        end
        StImmWb: RegWrite = 1'b1;
        StBranch: begin
          ALUSrcA     = 1'b1;
          ALUOp       = 3'b001;
          PCWriteCond = 1'b1;
          PCSource    = 2'b01;
        end
        StJump: begin
          PCWrite  = 1'b1;
          PCSource = 2'b10;
        end
        StTrap: begin
          PCWrite  = 1'b1;
          PCSource = 2'b11;
          trap     = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign state      = state_q;
  assign next_state = state_d;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: latency table, corner-case sequences and random
// instruction streams checked against a trace model built from the instruction rules.
module tb_multicycle_ctrl_fsm;

  localparam logic [5:0] OpR    = 6'b000000;
  localparam logic [5:0] OpAddi = 6'b001000;
  localparam logic [5:0] OpLw   = 6'b100011;
  localparam logic [5:0] OpSw   = 6'b101011;
  localparam logic [5:0] OpBeq  = 6'b000100;
  localparam logic [5:0] OpJ    = 6'b000010;
  localparam int         Tmo    = 15;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] Opcode = 6'd0;
  logic       mem_ready = 1'b0;
  logic [2:0] ALUOp;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       PCWrite;
  logic [1:0] PCSource;
  logic       PCWriteCond, MemRead, MemWrite, MemToReg, RegDst, RegWrite, IRWrite, trap;
  logic [3:0] state, next_state;

  always #5 clk = ~clk;

  multicycle_ctrl_fsm dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .mem_ready(mem_ready),
    .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCWrite(PCWrite),
    .PCSource(PCSource), .PCWriteCond(PCWriteCond), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemToReg(MemToReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .IRWrite(IRWrite), .trap(trap), .state(state), .next_state(next_state)
  );

  logic [16:0] dut_outs;
  assign dut_outs = {ALUOp, ALUSrcA, ALUSrcB, PCWrite, PCSource, PCWriteCond, MemRead,
                     MemWrite, MemToReg, RegDst, RegWrite, IRWrite, trap};

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Control outputs each state must drive, straight from the state table.
  function automatic logic [16:0] exp_outs(input int s, input bit rdy);
    logic [2:0] aluop = 3'b000;
    logic       srca = 1'b0;
    logic [1:0] srcb = 2'b00;
    logic       pcw = 1'b0;
    logic [1:0] pcs = 2'b00;
    logic       pcwc = 1'b0, mr = 1'b0, mw = 1'b0, m2r = 1'b0, rd = 1'b0;
    logic       rw = 1'b0, irw = 1'b0, tr = 1'b0;
    case (s)
      0:  begin mr = 1'b1; srcb = 2'b01; irw = rdy; pcw = rdy; end
      1:  srcb = 2'b11;
      2:  begin srca = 1'b1; srcb = 2'b10; end
      3:  mr = 1'b1;
      4:  begin rw = 1'b1; m2r = 1'b1; end
      5:  mw = 1'b1;
      6:  begin srca = 1'b1; aluop = 3'b010; end
      7:  begin rw = 1'b1; rd = 1'b1; end
      8:  begin srca = 1'b1; aluop = 3'b001; pcwc = 1'b1; pcs = 2'b01; end
      9:  begin pcw = 1'b1; pcs = 2'b10; end
      10: begin srca = 1'b1; srcb = 2'b10; aluop = 3'b011; end
      11: rw = 1'b1;
      12: begin pcw = 1'b1; pcs = 2'b11; tr = 1'b1; end
      default: ;
    endcase
    return {aluop, srca, srcb, pcw, pcs, pcwc, mr, mw, m2r, rd, rw, irw, tr};
  endfunction

  typedef struct {
    int         st;
    bit         rdy;
    logic [5:0] op;
  } cyc_t;

  cyc_t tr[$];

  function automatic logic [5:0] rop();
    return 6'($urandom);
  endfunction

  function automatic bit rbit();
    return 1'($urandom);
  endfunction

  task automatic push(input int st, input bit rdy, input logic [5:0] op);
    cyc_t c;
    c.st = st;
    c.rdy = rdy;
    c.op = op;
    tr.push_back(c);
  endtask

  // A memory access stalled w cycles: more than Tmo stalls ends in the trap.
  task automatic add_wait(input int st, input int w, output bit timed_out);
    if (w > Tmo) begin
      for (int i = 0; i <= Tmo; i++) push(st, 1'b0, rop());
      push(12, rbit(), rop());
      timed_out = 1'b1;
    end else begin
      for (int i = 0; i < w; i++) push(st, 1'b0, rop());
      push(st, 1'b1, rop());
      timed_out = 1'b0;
    end
  endtask

  task automatic build(input logic [5:0] op, input int wf, input int wm);
    bit to;
    tr.delete();
    add_wait(0, wf, to);
    if (to) return;
    push(1, rbit(), op);
    case (op)
      OpR:    begin push(6, rbit(), rop()); push(7, rbit(), rop()); end
      OpAddi: begin push(10, rbit(), rop()); push(11, rbit(), rop()); end
      OpBeq:  push(8, rbit(), rop());
      OpJ:    push(9, rbit(), rop());
      OpLw: begin
        push(2, rbit(), rop());
        add_wait(3, wm, to);
        if (!to) push(4, rbit(), rop());
      end
      OpSw: begin
        push(2, rbit(), rop());
        add_wait(5, wm, to);
      end
      default: push(12, rbit(), rop());
    endcase
  endtask

  task automatic run_trace(input string tag);
    int nxt;
    for (int i = 0; i < tr.size(); i++) begin
      Opcode = tr[i].op;
      mem_ready = tr[i].rdy;
      @(negedge clk);
      nxt = (i + 1 < tr.size()) ? tr[i+1].st : 0;
      chk($sformatf("%s[%0d] state", tag, i), 32'(state), 32'(tr[i].st));
      chk($sformatf("%s[%0d] next_state", tag, i), 32'(next_state), 32'(nxt));
      chk($sformatf("%s[%0d] outputs", tag, i), 32'(dut_outs),
          32'(exp_outs(tr[i].st, tr[i].rdy)));
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int pick_wait();
    int r = int'($urandom_range(0, 9));
    if (r < 7) return r % 4;
    return int'($urandom_range(14, 17));
  endfunction

  typedef struct {
    logic [5:0] op;
    int         lat;
    int         after_dec;
  } vec_t;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vecs[7];
    logic [5:0] legal[6];
    int         n, sd;

    vecs[0] = '{OpR,       4, 6};
    vecs[1] = '{OpAddi,    4, 10};
    vecs[2] = '{OpLw,      5, 2};
    vecs[3] = '{OpSw,      4, 2};
    vecs[4] = '{OpBeq,     3, 8};
    vecs[5] = '{OpJ,       3, 9};
    vecs[6] = '{6'b111111, 3, 12};
    legal   = '{OpR, OpAddi, OpLw, OpSw, OpBeq, OpJ};

    // Reset holds everything low even though FETCH with ready would raise IRWrite.
    reset = 1'b0;
    mem_ready = 1'b1;
    #3;
    chk("reset state", 32'(state), 32'd0);
    chk("reset next_state", 32'(next_state), 32'd0);
    chk("reset outputs", 32'(dut_outs), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    foreach (vecs[k]) begin
      n = 0;
      sd = -1;
      do begin
        Opcode = vecs[k].op;
        mem_ready = 1'b1;
        @(negedge clk);
        if (n == 2) sd = int'(state);
        @(posedge clk);
        #1;
        n++;
      end while (state != 4'd0 && n < 20);
      chk($sformatf("latency op=%b", vecs[k].op), 32'(n), 32'(vecs[k].lat));
      chk($sformatf("post-decode op=%b", vecs[k].op), 32'(sd), 32'(vecs[k].after_dec));
    end

    build(OpR, 0, 0);          run_trace("rtype");
    build(OpLw, 0, 3);         run_trace("lw_wait3");
    build(6'b111100, 0, 0);    run_trace("illegal");
    build(OpR, 16, 0);         run_trace("fetch_timeout");
    build(OpSw, 0, 20);        run_trace("sw_timeout");
    build(OpLw, Tmo, Tmo);     run_trace("ready_wins");
    build(OpBeq, 1, 0);        run_trace("beq");
    build(OpJ, 0, 0);          run_trace("jump");

    // Asynchronous reset in the middle of a stalled load.
    Opcode = OpLw;
    mem_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    chk("pre-reset in MEM_RD", 32'(state), 32'd3);
    #2;
    reset = 1'b0;
    #1;
    chk("async reset state", 32'(state), 32'd0);
    chk("async reset next_state", 32'(next_state), 32'd0);
    chk("async reset outputs", 32'(dut_outs), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("post-reset outputs", 32'(dut_outs), 32'(exp_outs(0, 1'b0)));
    @(posedge clk); #1;
    chk("post-reset holds FETCH", 32'(state), 32'd0);
    build(OpR, 0, 0);          run_trace("after_reset");

    for (int i = 0; i < 150; i++) begin
      int idx = int'($urandom_range(0, 7));
      logic [5:0] op = (idx < 6) ? legal[idx] : rop();
      build(op, pick_wait(), pick_wait());
      run_trace($sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
